beat_sequencer: RTL

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

---
 rtl/beat_sequencer_pkg.sv | 20 ++
 rtl/beat_sequencer_digit_counter.sv | 27 ++
 rtl/beat_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/beat_sequencer_pkg.sv
// Shared types and constants for the beat sequencer: state encoding, stop code, default beat length.
package beat_sequencer_pkg;

    localparam int         DEFAULT_LINE_LENGTH = 40;
    localparam logic [5:0] STP_FUNC_CODE       = 6'b111010;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_SCAN1   = 3'd1,
        ST_ACTION1 = 3'd2,
        ST_SCAN2   = 3'd3,
        ST_ACTION2 = 3'd4
    } beat_state_t;

    // Counter width for a modulo-len count; never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/beat_sequencer_digit_counter.sv
// Digit-period counter: counts 0..LEN-1, pulses wrap on the last digit, held at zero by hold.
// Latency: count updates one clock after the digit; wrap is combinational from count.
// Backpressure: none, free-running whenever hold is low.
module digit_counter #(
    parameter int LEN = 40,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = !hold && (count == W'(LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (hold || wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Four-beat machine cycle sequencer (SCAN1/ACTION1/SCAN2/ACTION2) with run, single-shot and stop.
// Latency: starts one clock after run/KSS edge; beat outputs decode the registered state.
// Backpressure: none. Optional blackout digits per beat with BEAT_SEQUENCER_BLACKOUT_EN.
module beat_sequencer
    import beat_sequencer_pkg::*;
#(
    parameter int                             LINE_LENGTH         = DEFAULT_LINE_LENGTH,
    parameter int                             INSTR_FUNCTION_BITS = 6,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_STP            = STP_FUNC_CODE,
    parameter int                             BLACKOUT_LEN        = 4,
`ifdef BEAT_SEQUENCER_BLACKOUT_EN
    localparam bit                            BLACKOUT_EN         = 1'b1,
`else
    localparam bit                            BLACKOUT_EN         = 1'b0,
`endif
    localparam int                            BEATLEN             = LINE_LENGTH + (BLACKOUT_EN ? BLACKOUT_LEN : 0),
    localparam int                            DIGIT_W             = cnt_width(BEATLEN)
) (
    input  logic                           w_CLK,
    input  logic                           w_RST,
    input  logic                           w_RUN,
    input  logic                           w_KSS,
    input  logic [INSTR_FUNCTION_BITS-1:0] b_PI_FUNC,
    output logic                           w_SCAN1,
    output logic                           w_ACTION1,
    output logic                           w_SCAN2,
    output logic                           w_ACTION2,
    output logic                           w_PARA_ACTION,
    output logic [INSTR_FUNCTION_BITS-1:0] b_FST,
    output logic [DIGIT_W-1:0]             b_DIGIT,
    output logic                           w_DIGIT0,
    output logic                           w_BEAT_END,
    output logic                           w_STOPPED
);

    beat_state_t        state, state_nxt;
    logic               running, beat_end, blackout;
    logic               kss_prev, kss_rise, run_block, start, fst_load;
    logic [DIGIT_W-1:0] digit;

    assign running  = (state != ST_STOPPED);
    assign kss_rise = w_KSS & ~kss_prev;
    // A run level left high across a programmed stop must not restart the machine.
    assign start    = (w_RUN & ~run_block) | kss_rise;

    digit_counter #(
        .LEN (BEATLEN),
        .W   (DIGIT_W)
    ) u_digit (
        .clk   (w_CLK),
        .rst   (w_RST),
        .hold  (!running),
        .count (digit),
        .wrap  (beat_end)
    );

`ifdef BEAT_SEQUENCER_BLACKOUT_EN
    assign blackout = running && (digit >= DIGIT_W'(LINE_LENGTH));
`else
    assign blackout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fst_load  = 1'b0;
        case (state)
            ST_STOPPED: if (start) state_nxt = ST_SCAN1;
            ST_SCAN1:   if (beat_end) state_nxt = ST_ACTION1;
            ST_ACTION1: if (beat_end) begin
                state_nxt = ST_SCAN2;
                fst_load  = 1'b1;
            end
            ST_SCAN2:   if (beat_end) state_nxt = ST_ACTION2;
            ST_ACTION2: if (beat_end) begin
                if (b_FST == INST_STP) state_nxt = ST_STOPPED;
                else if (w_RUN)        state_nxt = ST_SCAN1;
                else                   state_nxt = ST_STOPPED;
            end
            default:    state_nxt = ST_STOPPED;
        endcase
    end

    always_ff @(posedge w_CLK or posedge w_RST) begin
        if (w_RST) begin
            state    <= ST_STOPPED;
            kss_prev <= 1'b0;
        end else begin
            state    <= state_nxt;
            kss_prev <= w_KSS;
        end
    end

    always_ff @(posedge w_CLK or posedge w_RST) begin
        if (w_RST) begin
            run_block <= 1'b0;
        end else if (!w_RUN) begin
            run_block <= 1'b0;
        end else if (state == ST_ACTION2 && beat_end && state_nxt == ST_STOPPED) begin
            run_block <= 1'b1;
        end
    end

    always_ff @(posedge w_CLK or posedge w_RST) begin
        if (w_RST) begin
            b_FST <= '0;
        end else if (fst_load) begin
            b_FST <= b_PI_FUNC;
        end
    end

    assign w_SCAN1       = (state == ST_SCAN1);
    assign w_ACTION1     = (state == ST_ACTION1);
    assign w_SCAN2       = (state == ST_SCAN2);
    assign w_ACTION2     = (state == ST_ACTION2);
    assign w_PARA_ACTION = w_ACTION2 & ~blackout;
    assign w_STOPPED     = !running;
    assign b_DIGIT       = digit;
    assign w_DIGIT0      = running && (digit == '0);
    assign w_BEAT_END    = beat_end;

endmodule
